// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mlp_pkg
// Brief    : Shared types and helpers for the sequenced MLP layer: FSM state
//            encoding, activation select constants, saturation bounds.
// Revision : 1.0  initial release
// ============================================================================
package mlp_pkg;

  // Layer sequencer states (explicit 3-bit encoding)
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    ACT   = 3'd3,
    OUT   = 3'd4
  } mlp_state_t;

  // Activation select values as seen on act_relu
  localparam logic ACT_RELU  = 1'b1;
  localparam logic ACT_IDENT = 1'b0;

  // Largest signed value representable in 'width' bits
  function automatic longint sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in 'width' bits
  function automatic longint sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_sat_act.sv
`default_nettype none
// ============================================================================
// Module   : mlp_sat_act
// Brief    : Combinational fixed-point rescale (arithmetic right shift) then
//            ReLU+clip or identity+signed clamp into OUT_WIDTH bits.
// Revision : 1.0  initial release
// ============================================================================
module mlp_sat_act #(
  parameter int MAC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 0
) (
  input  logic [MAC_WIDTH-1:0] acc,
  input  logic                 act_relu,
  output logic [OUT_WIDTH-1:0] act_out
);
  import mlp_pkg::*;

  localparam logic signed [MAC_WIDTH-1:0] c_max = MAC_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [MAC_WIDTH-1:0] c_min = MAC_WIDTH'(sat_min(OUT_WIDTH));

  logic signed [MAC_WIDTH-1:0] w_s;

  assign w_s = $signed(acc) >>> FRAC_SHIFT;

  // Positive overflow clips for both modes; the negative side depends on mode
  always_comb begin
    act_out = w_s[OUT_WIDTH-1:0];
    if (w_s > c_max) begin
      act_out = c_max[OUT_WIDTH-1:0];
    end else if ((act_relu == ACT_RELU) && w_s[MAC_WIDTH-1]) begin
      act_out = '0;
    end else if ((act_relu == ACT_IDENT) && (w_s < c_min)) begin
      act_out = c_min[OUT_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mlp_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : mlp_layer_seq
// Brief    : Self-sequencing fully-connected layer. Streams N_INPUTS samples
//            over valid/ready, MACs them against per-neuron weight RAMs in
//            parallel, applies activation and presents all neuron outputs
//            over valid/ready.
//            Optional macro MLP_LAYER_BIAS_EN adds a per-neuron bias register
//            written through wr_col == N_INPUTS.
// Revision : 1.0  initial release
// ============================================================================
module mlp_layer_seq #(
  parameter int N_INPUTS   = 2,
  parameter int N_NEURONS  = 4,
  parameter int IN_WIDTH   = 16,
  parameter int WGT_WIDTH  = 16,
  parameter int MAC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 0,
  localparam int ROW_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  localparam int COL_W = $clog2(N_INPUTS + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [ROW_W-1:0]               wr_row,
  input  logic [COL_W-1:0]               wr_col,
  input  logic [WGT_WIDTH-1:0]           wr_weight,
  input  logic                           act_relu,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_WIDTH-1:0]            in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_NEURONS*OUT_WIDTH-1:0] outputs_flat,
  output logic                           busy
);
  import mlp_pkg::*;

  localparam int AW     = $clog2(N_INPUTS);
  localparam int PROD_W = IN_WIDTH + WGT_WIDTH;

  mlp_state_t                     r_state;
  mlp_state_t                     w_state_nxt;
  logic [AW-1:0]                  r_cnt;
  logic signed [IN_WIDTH-1:0]     r_x;
  logic                           r_mac_en;
  logic                           r_first;
  logic                           r_act_relu;
  logic [N_NEURONS*OUT_WIDTH-1:0] r_out;
  logic [N_NEURONS*OUT_WIDTH-1:0] w_act_flat;
  logic                           w_wr_ok;
  logic                           w_in_hs;
  logic                           w_last_beat;
  logic [AW-1:0]                  w_rd_addr;

  // Writes only land in IDLE; in_ready is forced low in that cycle so a write
  // and a sample can never share the RAM address port.
  assign w_wr_ok     = wr_en && rst_n && (r_state == IDLE);
  assign w_in_hs     = in_valid && in_ready;
  assign w_last_beat = (r_cnt == AW'(N_INPUTS - 1));
  assign w_rd_addr   = w_wr_ok ? wr_col[AW-1:0] : r_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_in_hs) w_state_nxt = ACCUM;
      ACCUM:   if (w_in_hs && w_last_beat) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = ACT;
      ACT:     w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (r_state != IDLE);
    case (r_state)
      IDLE:    in_ready  = rst_n && !wr_en;
      ACCUM:   in_ready  = rst_n;
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  // Beat counter and the sample/control pipeline stage aligned with RAM read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_x        <= '0;
      r_mac_en   <= 1'b0;
      r_first    <= 1'b0;
      r_act_relu <= ACT_IDENT;
    end else begin
      r_mac_en <= w_in_hs;
      if (w_in_hs) begin
        r_x     <= in_data;
        r_first <= (r_cnt == '0);
        r_cnt   <= w_last_beat ? '0 : r_cnt + 1'b1;
        if (r_cnt == '0) r_act_relu <= act_relu;
      end
    end
  end

  for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
    logic [WGT_WIDTH-1:0]        r_mem [N_INPUTS];
    logic signed [WGT_WIDTH-1:0] r_w;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [MAC_WIDTH-1:0] w_init;
    logic signed [MAC_WIDTH-1:0] r_acc;
    logic [OUT_WIDTH-1:0]        w_act;
    logic                        w_sel;

    assign w_sel = w_wr_ok && (wr_row == ROW_W'(n));

    // Weight RAM: single port, write in IDLE, synchronous read
    always_ff @(posedge clk) begin
      if (w_sel && (wr_col < COL_W'(N_INPUTS))) r_mem[wr_col[AW-1:0]] <= wr_weight;
      r_w <= r_mem[w_rd_addr];
    end

`ifdef MLP_LAYER_BIAS_EN
    logic signed [WGT_WIDTH-1:0] r_bias;

    // Bias register, held across reset like the weights
    always_ff @(posedge clk) begin
      if (w_sel && (wr_col == COL_W'(N_INPUTS))) r_bias <= wr_weight;
    end

    // Bias is given in output Q-format; lift it to accumulator scale
    assign w_init = MAC_WIDTH'(r_bias) <<< FRAC_SHIFT;
`else
    assign w_init = '0;
`endif

    assign w_prod = r_x * r_w;

    // Beat 0 seeds the accumulator, so no separate clear cycle is needed
    always_ff @(posedge clk) begin
      if (!rst_n)        r_acc <= '0;
      else if (r_mac_en) r_acc <= (r_first ? w_init : r_acc) + MAC_WIDTH'(w_prod);
    end

    mlp_sat_act #(
      .MAC_WIDTH (MAC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .FRAC_SHIFT(FRAC_SHIFT)
    ) u_sat_act (
      .acc     (r_acc),
      .act_relu(r_act_relu),
      .act_out (w_act)
    );

    assign w_act_flat[n*OUT_WIDTH +: OUT_WIDTH] = w_act;
  end

  // Result register: loaded only in ACT, so it holds steady through OUT
  always_ff @(posedge clk) begin
    if (!rst_n)               r_out <= '0;
    else if (r_state == ACT)  r_out <= w_act_flat;
  end

  assign outputs_flat = r_out;

endmodule
`default_nettype wire

// File: tb/tb_mlp_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlp_layer_seq
// Brief    : Directed self-checking bench for mlp_layer_seq. Main instance at
//            FRAC_SHIFT=0; a second instance at FRAC_SHIFT=8 for Q-format
//            rescale and (when MLP_LAYER_BIAS_EN is defined) bias.
// Revision : 1.0  initial release
// ============================================================================
module tb_mlp_layer_seq;

`ifdef MLP_LAYER_BIAS_EN
  localparam logic [15:0] c_n3_bias = 16'h1234;
  localparam logic [15:0] c_q_n0    = 16'h0B05;
`else
  localparam logic [15:0] c_n3_bias = 16'h0000;
  localparam logic [15:0] c_q_n0    = 16'h0B00;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst_n, wr_en, act_relu, in_valid, out_ready;
  logic [1:0]  wr_row, wr_col;
  logic [15:0] wr_weight, in_data;
  logic        in_ready, out_valid, busy;
  logic [63:0] outputs_flat;

  // Q8 instance
  logic        q_rst_n, q_wr_en, q_act_relu, q_in_valid, q_out_ready;
  logic [1:0]  q_wr_row, q_wr_col;
  logic [15:0] q_wr_weight, q_in_data;
  logic        q_in_ready, q_out_valid, q_busy;
  logic [63:0] q_outputs_flat;

  mlp_layer_seq u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_weight(wr_weight), .act_relu(act_relu), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .outputs_flat(outputs_flat), .busy(busy)
  );

  mlp_layer_seq #(.FRAC_SHIFT(8)) u_dut_q8 (
    .clk(clk), .rst_n(q_rst_n), .wr_en(q_wr_en), .wr_row(q_wr_row), .wr_col(q_wr_col),
    .wr_weight(q_wr_weight), .act_relu(q_act_relu), .in_valid(q_in_valid),
    .in_ready(q_in_ready), .in_data(q_in_data), .out_valid(q_out_valid),
    .out_ready(q_out_ready), .outputs_flat(q_outputs_flat), .busy(q_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] row, input logic [1:0] col, input logic [15:0] val);
    wr_en = 1'b1; wr_row = row; wr_col = col; wr_weight = val;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic q_wr(input logic [1:0] row, input logic [1:0] col, input logic [15:0] val);
    q_wr_en = 1'b1; q_wr_row = row; q_wr_col = col; q_wr_weight = val;
    @(posedge clk); #1;
    q_wr_en = 1'b0;
  endtask

  // Present one sample until accepted; stalls = cycles spent waiting
  task automatic beat(input logic [15:0] x, output int stalls);
    logic hs;
    hs = 1'b0; stalls = 0;
    in_valid = 1'b1; in_data = x;
    while (!hs && stalls < 50) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
      if (!hs) stalls++;
    end
    if (!hs) check("beat_timeout", hs, 1'b1);
    in_valid = 1'b0;
  endtask

  // After last beat: out_valid must appear in the third cycle after the
  // handshake cycle, i.e. two further edges from here; then consume it.
  task automatic finish_vec(input string tag, input logic [63:0] exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"}, lat, 2);
    check({tag, "_out"}, outputs_flat, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  // act_relu is flipped after beat 0 to confirm it is sampled only there
  task automatic run_vec(input logic [15:0] x0, input logic [15:0] x1, input logic relu,
                         input string tag, input logic [63:0] exp);
    int st;
    act_relu = relu;
    beat(x0, st);
    act_relu = ~relu;
    beat(x1, st);
    finish_vec(tag, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st;
    int lat;
    rst_n = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_weight = '0;
    act_relu = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    q_rst_n = 1'b0; q_wr_en = 1'b0; q_wr_row = '0; q_wr_col = '0; q_wr_weight = '0;
    q_act_relu = 1'b0; q_in_valid = 1'b0; q_in_data = '0; q_out_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1; q_rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_flat", outputs_flat, 64'h0);
    check("idle_in_ready", in_ready, 1'b1);

    // ---------------- weights ----------------
    wr(2'd0, 2'd0, 16'h0001); wr(2'd0, 2'd1, 16'h0002);
    wr(2'd1, 2'd0, 16'hFFFF); wr(2'd1, 2'd1, 16'hFFFF);
    wr(2'd2, 2'd0, 16'h7FFF); wr(2'd2, 2'd1, 16'h7FFF);
    wr(2'd3, 2'd0, 16'h0000); wr(2'd3, 2'd1, 16'h0000);
    for (int r = 0; r < 4; r++) wr(2'(r), 2'd2, 16'h0000);

    // n0=11, n1=-7->0, n2=229369->7FFF, n3=0
    run_vec(16'd3, 16'd4, 1'b1, "relu", 64'h0000_7FFF_0000_000B);
    // identity keeps -7
    run_vec(16'd3, 16'd4, 1'b0, "ident", 64'h0000_7FFF_FFF9_000B);
    // n1 = 2*(-32768*32767) -> clamp 8000; n0 = 98301 -> 7FFF
    wr(2'd1, 2'd0, 16'h8000); wr(2'd1, 2'd1, 16'h8000);
    run_vec(16'h7FFF, 16'h7FFF, 1'b0, "ident_min", 64'h0000_7FFF_8000_7FFF);

    // ---------------- output backpressure ----------------
    act_relu = 1'b1;
    beat(16'd3, st);
    beat(16'd4, st);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_lat", lat, 2);
    act_relu = 1'b0;
    in_valid = 1'b1; in_data = 16'd2;   // next vector already waiting
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1'b1);
      check("bp_flat", outputs_flat, 64'h0000_7FFF_0000_000B);
      check("bp_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1'b1);

    // ---------------- in_valid gaps 1,0,0,1 and dropped write ----------------
    beat(16'd2, st);
    check("bp_next_accept", st, 0);
    wr(2'd0, 2'd1, 16'd100);            // in ACCUM: must be dropped
    @(posedge clk); #1;
    check("gap_busy", busy, 1'b1);
    beat(16'd5, st);
    // n0 = 2+10 = 12, n1 = 7*(-32768) -> 8000, n2 = 7*32767 -> 7FFF
    finish_vec("gap", 64'h0000_7FFF_8000_000C);

    // ---------------- write wins over in_valid; illegal column ----------------
    act_relu = 1'b1;
    in_valid = 1'b1; in_data = 16'd3;
    wr_en = 1'b1; wr_row = 2'd3; wr_col = 2'd2; wr_weight = 16'h1234;
    #1;
    check("wr_blocks_in", in_ready, 1'b0);
    @(posedge clk); #1;
    wr_en = 1'b0; in_valid = 1'b0;
    check("wr_blocks_busy", busy, 1'b0);
    wr(2'd3, 2'd3, 16'h5555);           // column beyond bias slot: ignored
    run_vec(16'd3, 16'd4, 1'b1, "bias_slot", {c_n3_bias, 48'h7FFF_0000_000B});

    // ---------------- reset mid-vector ----------------
    act_relu = 1'b1;
    beat(16'd3, st);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_flat", outputs_flat, 64'h0);
    check("mid_rst_ready", in_ready, 1'b1);
    run_vec(16'd3, 16'd4, 1'b1, "post_rst", {c_n3_bias, 48'h7FFF_0000_000B});

    // ---------------- Q8 rescale (and bias when enabled) ----------------
    for (int r = 0; r < 4; r++) begin
      q_wr(2'(r), 2'd0, 16'h0000);
      q_wr(2'(r), 2'd1, 16'h0000);
      q_wr(2'(r), 2'd2, 16'h0000);
    end
    q_wr(2'd0, 2'd0, 16'h0100);
    q_wr(2'd0, 2'd1, 16'h0200);
    q_wr(2'd0, 2'd2, 16'h0005);
    q_act_relu = 1'b1;
    q_in_valid = 1'b1; q_in_data = 16'h0300;
    #1;
    check("q_ready0", q_in_ready, 1'b1);
    @(posedge clk); #1;
    q_in_data = 16'h0400;
    check("q_ready1", q_in_ready, 1'b1);
    @(posedge clk); #1;
    q_in_valid = 1'b0;
    lat = 0;
    while (!q_out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("q_lat", lat, 2);
    check("q_out", q_outputs_flat, {48'h0, c_q_n0});
    q_out_ready = 1'b1;
    @(posedge clk); #1;
    q_out_ready = 1'b0;
    check("q_idle", q_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
